// File: rtl/hack_pkg.sv
// Shared types and constants for the serial-SRAM memory controller.
//   spi_state_t    : controller FSM states (StInit only with SPI_MEM_INIT_EN)
//   SPI_CMD_*      : 23LC1024 instruction bytes
//   SPI_MODE_SEQ   : mode-register value selecting sequential mode
//   SPI_FRAME_BITS : length of a single-word read/write frame
//   SPI_INIT_BITS  : length of the mode-register write frame
// Optional feature macro: SPI_MEM_INIT_EN.
package hack_pkg;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SPI_CMD_WRMR  = 8'h01;
  localparam logic [7:0] SPI_MODE_SEQ  = 8'h40;

  localparam int unsigned SPI_FRAME_BITS = 48;
  localparam int unsigned SPI_INIT_BITS  = 16;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCsSetup = 3'd1,
    StShift   = 3'd2,
    StCsHold  = 3'd3,
    StDone    = 3'd4
`ifdef SPI_MEM_INIT_EN
    ,
    StInit    = 3'd5
`endif
  } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period counter producing the SPI clock level and one-cycle
// strobes marking the clk edge at which SCLK rises or falls.
//   clk, resetb : system clock, async active-low reset
//   en_i        : run; when low the counter and SCLK are held in the low phase
//   sclk_o      : SCLK level (idles low)
//   rise_o      : high in the cycle whose closing edge raises SCLK
//   fall_o      : high in the cycle whose closing edge lowers SCLK
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic resetb,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            lvl_q;
  logic            last;

  always_comb begin
    last   = (cnt_q == CntLast);
    rise_o = en_i && last && !lvl_q;
    fall_o = en_i && last && lvl_q;
    sclk_o = lvl_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else if (last) begin
      cnt_q <= '0;
      lvl_q <= ~lvl_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 master executing single-word CPU memory transactions on a
// 23LC1024-class serial SRAM (24-bit byte address, word stored big-endian at 2*addr).
//   clk, resetb      : system clock, async active-low reset
//   start_i          : transaction request (level, sampled in idle only)
//   rwb_i            : 1 = read, 0 = write
//   addr_i, wdata_i  : word address and write data
//   rdata_o          : last word read (registered)
//   halt_o           : combinational stall to the CPU control FSM
//   done_o           : one-cycle completion pulse
//   sclk_o, cs_n_o, mosi_o, miso_i : SPI pins
// Parameter CLK_DIV: SCLK half-period in clk cycles (>= 1).
// Macro SPI_MEM_INIT_EN: after reset write the mode register (sequential) first.
module spi_mem_ctrl
  import hack_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        start_i,
  input  logic        rwb_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        halt_o,
  output logic        done_o,
  output logic        sclk_o,
  output logic        cs_n_o,
  output logic        mosi_o,
  input  logic        miso_i
);

  localparam int unsigned CntW = $clog2(CLK_DIV + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
`ifdef SPI_MEM_INIT_EN
  localparam spi_state_t ResetState = StInit;
`else
  localparam spi_state_t ResetState = StIdle;
`endif

  spi_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      bit_q, bit_d;
  logic [47:0]     tx_q, tx_d;
  logic [15:0]     rx_q, rx_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            rwb_q, rwb_d;
  logic [5:0]      last_bit;
  logic            cs_active;
  logic            clk_en, sclk_rise, sclk_fall;
`ifdef SPI_MEM_INIT_EN
  logic            init_q, init_d;
`endif

  spi_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .resetb(resetb),
    .en_i  (clk_en),
    .sclk_o(sclk_o),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rwb_d    = rwb_q;
    clk_en   = (state_q == StShift);
    last_bit = 6'(SPI_FRAME_BITS - 1);
`ifdef SPI_MEM_INIT_EN
    init_d   = init_q;
    if (init_q) last_bit = 6'(SPI_INIT_BITS - 1);
`endif

    unique case (state_q)
`ifdef SPI_MEM_INIT_EN
      StInit: begin
        tx_d    = {SPI_CMD_WRMR, SPI_MODE_SEQ, 32'h0};
        init_d  = 1'b1;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = StCsSetup;
      end
`endif
      StIdle: begin
        if (start_i) begin
          rwb_d   = rwb_i;
          tx_d    = rwb_i ? {SPI_CMD_READ, 7'b0, addr_i, 1'b0, 16'h0}
                          : {SPI_CMD_WRITE, 7'b0, addr_i, 1'b0, wdata_i};
          cnt_d   = '0;
          bit_d   = '0;
          state_d = StCsSetup;
        end
      end
      StCsSetup: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShift: begin
        if (sclk_rise) rx_d = {rx_q[14:0], miso_i};
        if (sclk_fall) begin
          tx_d = {tx_q[46:0], 1'b0};
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = StCsHold;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StCsHold: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
`ifdef SPI_MEM_INIT_EN
          // Mode-register write is invisible to the CPU: no done pulse.
          if (init_q) begin
            init_d  = 1'b0;
            state_d = StIdle;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (rwb_q) rdata_d = rx_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cs_active = (state_q == StCsSetup) || (state_q == StShift) || (state_q == StCsHold);
    halt_o    = cs_active || ((state_q == StIdle) && start_i);
`ifdef SPI_MEM_INIT_EN
    if (state_q == StInit) halt_o = 1'b1;
`endif
    cs_n_o    = !cs_active;
    done_o    = (state_q == StDone);
    mosi_o    = tx_q[47];
    rdata_o   = rdata_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rwb_q   <= 1'b0;
`ifdef SPI_MEM_INIT_EN
      init_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rwb_q   <= rwb_d;
`ifdef SPI_MEM_INIT_EN
      init_q  <= init_d;
`endif
    end
  end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

SPI master that executes the single-word memory transactions requested by the CPU control FSM. It sits directly downstream of the FSM: it consumes its start, read/write, address and data requests, and returns `halt_o`, which freezes the FSM while a transfer is in flight. It drives an external 23LC1024-class serial SRAM in SPI mode 0 with 24-bit byte addressing. Each 16-bit Hack word is stored big-endian at byte address `2*addr`.

## Interface
Parameters:
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles; legal range is 1 or more.

Ports:
- `clk` in 1: system clock.
- `resetb` in 1: reset, asynchronous, active-low. Clock is `clk`.
- `start_i` in 1: request a transaction; level-sensitive; sampled only in IDLE.
- `rwb_i` in 1: 1 = read, 0 = write.
- `addr_i` in 16: word address.
- `wdata_i` in 16: write data.
- `rdata_o` out 16: last word read; registered.
- `halt_o` out 1: stall to FSM; combinational.
- `done_o` out 1: one-cycle pulse when a transaction completes.
- `sclk_o` out 1: SPI clock; idles low.
- `cs_n_o` out 1: chip select, active-low.
- `mosi_o` out 1: serial data to memory.
- `miso_i` in 1: serial data from memory.

## Operation
- States: INIT (only with the macro), IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
- IDLE with `start_i`=1:
  - Latch `rwb_i`, `addr_i` and `wdata_i`.
  - Load the 48-bit shift frame `{cmd, 7'b0, addr, 1'b0, data}`.
  - `cmd` is 0x03 for a read or 0x02 for a write. `data` is `wdata` for a write and 0 for a read.
  - Go to CS_SETUP.
- CS_SETUP: `cs_n_o`=0 for `CLK_DIV` cycles, with `mosi_o` = frame MSB.
- SHIFT: 48 SCLK periods, MSB first, mode 0.
  - `sclk_o` rises after `CLK_DIV` cycles and falls after `2*CLK_DIV` cycles.
  - `miso_i` is sampled at the rising edge.
  - `mosi_o` advances at the falling edge.
  - The bit counter counts 0..47. After the 48th falling edge, go to CS_HOLD.
- CS_HOLD: `cs_n_o` stays 0 for `CLK_DIV` cycles, then goes to DONE.
- DONE: lasts 1 cycle.
  - `cs_n_o`=1 and `done_o`=1.
  - For a read, `rdata_o` takes the last 16 sampled bits, first sampled bit = bit 15. For a write, `rdata_o` is unchanged.
  - `start_i` is ignored in DONE. The state returns to IDLE.
- `halt_o` = (IDLE and `start_i`) or CS_SETUP or SHIFT or CS_HOLD or INIT.
  - `halt_o` is low in DONE, so the FSM advances exactly at the edge that leaves DONE.
  - The FSM then drops `start_i` or presents a new request; any new request is seen in the next IDLE cycle.
- Inputs are ignored outside IDLE; latched values are used throughout the transfer.
- `rdata_o` holds its value until the next read completes.

## Timing
- Reset values: state = IDLE (or INIT with the macro), `rdata_o`=0, `done_o`=0, `cs_n_o`=1, `sclk_o`=0, `mosi_o`=0. `halt_o` then follows `start_i`.
- Reset mid-transfer: outputs return to their reset values immediately (asynchronous). No partial `rdata_o` update.
- Latency from the `start_i` sample edge to `done_o`: `CLK_DIV` + 96·`CLK_DIV` + `CLK_DIV` cycles.
  - With `CLK_DIV`=2 this is 196 cycles; `done_o` is high in cycle 197.
- Back-to-back requests: at least 1 IDLE cycle between consecutive transfers (DONE → IDLE → CS_SETUP).
- `cs_n_o` is low from CS_SETUP entry through the CS_HOLD exit.

## Configuration
- `SPI_MEM_INIT_EN` defined:
  - After reset, the block enters INIT and sends the 16-bit frame 0x01,0x40 (WRMR, sequential mode) using the same setup/shift/hold timing.
  - `halt_o`=1 throughout INIT. Then go to IDLE, with no `done_o` pulse.
- Undefined: the INIT state is absent, reset goes straight to IDLE, and the memory is assumed to be in its power-on mode.

## Structure
- `hack_pkg`:
  - `spi_state_t` enum.
  - Command constants `SPI_CMD_READ`=0x03, `SPI_CMD_WRITE`=0x02, `SPI_CMD_WRMR`=0x01, `SPI_MODE_SEQ`=0x40.
  - `SPI_FRAME_BITS`=48.
- Sub-module `spi_clk_gen`:
  - Half-period counter that produces the SCLK level and one-cycle `rise`/`fall` strobes.
  - Enabled only during SHIFT; reset to a low phase.

## Test plan
- Read: `addr_i`=0x1234, memory model returns 0xBEEF.
  - MOSI must show 0x03, 0x00, 0x24, 0x68.
  - `rdata_o`=0xBEEF and `done_o` pulses at cycle 197 (`CLK_DIV`=2).
- Write: `addr_i`=0x0001, `wdata_i`=0xA55A.
  - MOSI must show 0x02, 0x00, 0x00, 0x02, 0xA5, 0x5A.
  - `rdata_o` is unchanged and `cs_n_o` has exactly one low window.
- Halt handshake with the FSM model:
  - `halt_o` is high in the same cycle `start_i` rises and stays high until DONE.
  - The FSM advances exactly once per transaction.
- Back-to-back read then write:
  - Two distinct `cs_n_o` windows with at least 1 IDLE cycle between them.
  - The latched address is unaffected by `addr_i` changing mid-transfer.
- Reset asserted at bit 20 of a read:
  - `cs_n_o`=1 and `sclk_o`=0 immediately, and `rdata_o`=0.
  - The next read completes correctly.
- With `SPI_MEM_INIT_EN`: after reset, the frame 0x01,0x40 is sent with `halt_o`=1, and a `start_i` held high is serviced only afterwards.
